// File: rtl/pc_controller_if.sv
// IF-stage sequencer bus: hazard/branch/imem inputs and PC/strobe/flush outputs of pc_controller.
interface pc_controller_if;
    logic        IMEM_BUSYWAIT;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        IMEM_READ;
    logic        FETCH_VALID;
    logic        FLUSH_IFID;
    logic        FLUSH_IDEX;
    logic        MISALIGN_EXC;

    modport master (
        input  IMEM_BUSYWAIT, STALL, BRANCH_TAKEN, BRANCH_TARGET,
        output PC, PC_PLUS4, IMEM_READ, FETCH_VALID, FLUSH_IFID, FLUSH_IDEX, MISALIGN_EXC
    );

    modport slave (
        output IMEM_BUSYWAIT, STALL, BRANCH_TAKEN, BRANCH_TARGET,
        input  PC, PC_PLUS4, IMEM_READ, FETCH_VALID, FLUSH_IFID, FLUSH_IDEX, MISALIGN_EXC
    );
endinterface

// File: rtl/pc_controller.sv
// IF-stage PC sequencer: advance / hold / redirect with pending-redirect capture across imem busywait.
// Optional feature macro MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VECTOR.
module pc_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic              CLOCK,
    input  logic              RESET,
    pc_controller_if.master   bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FETCH    = 2'd1;
    localparam logic [1:0] WAIT_MEM = 2'd2;

    logic [1:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4;
    logic        pend_valid, pend_valid_nxt;
    logic [31:0] pend_target, pend_target_nxt;
    logic        redirect;
    logic [31:0] redir_addr;
    logic        flush;
    logic        imem_read;

    function automatic logic [31:0] redirect_pc(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? TRAP_VECTOR : t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        redirect        = 1'b0;
        redir_addr      = pend_target;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (bus.BRANCH_TAKEN && !bus.IMEM_BUSYWAIT) begin
                    redirect   = 1'b1;
                    redir_addr = bus.BRANCH_TARGET;
                end else if (bus.IMEM_BUSYWAIT) begin
                    state_nxt = WAIT_MEM;
                    if (bus.BRANCH_TAKEN) begin
                        pend_valid_nxt  = 1'b1;
                        pend_target_nxt = bus.BRANCH_TARGET;
                    end
                end else if (!bus.STALL) begin
                    pc_nxt = pc_plus4;
                end
            end
            WAIT_MEM: begin
                // A redirect arriving while memory is busy replaces any older pending one.
                if (bus.BRANCH_TAKEN) begin
                    pend_valid_nxt  = 1'b1;
                    pend_target_nxt = bus.BRANCH_TARGET;
                end
                if (!bus.IMEM_BUSYWAIT) begin
                    state_nxt      = FETCH;
                    pend_valid_nxt = 1'b0;
                    if (bus.BRANCH_TAKEN) begin
                        redirect   = 1'b1;
                        redir_addr = bus.BRANCH_TARGET;
                    end else if (pend_valid) begin
                        redirect   = 1'b1;
                        redir_addr = pend_target;
                    end else if (!bus.STALL) begin
                        pc_nxt = pc_plus4;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect) pc_nxt = redirect_pc(redir_addr);
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign;
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            pend_valid <= 1'b0;
            flush      <= 1'b0;
            imem_read  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_valid <= pend_valid_nxt;
            flush      <= redirect;
            imem_read  <= (state_nxt != IDLE);
`ifdef MISALIGN_TRAP_EN
            misalign   <= redirect && (redir_addr[1:0] != 2'b00);
`endif
        end
    end

    // Target is only meaningful while pend_valid is set, so it carries no reset.
    always_ff @(posedge CLOCK) begin
        pend_target <= pend_target_nxt;
    end

    assign bus.PC          = pc;
    assign bus.PC_PLUS4    = pc_plus4;
    assign bus.IMEM_READ   = imem_read;
    assign bus.FETCH_VALID = (state == FETCH) && !bus.IMEM_BUSYWAIT && !bus.BRANCH_TAKEN && !flush;
    assign bus.FLUSH_IFID  = flush;
    assign bus.FLUSH_IDEX  = flush;
`ifdef MISALIGN_TRAP_EN
    assign bus.MISALIGN_EXC = misalign;
`else
    assign bus.MISALIGN_EXC = 1'b0;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: directed scenarios plus randomized run against a reference model.
module tb_pc_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_controller_if bus();

    pc_controller dut (
        .CLOCK (clk),
        .RESET (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Reference model: running flag, "fetch stalled on memory" flag, PC and one pending redirect.
    logic        m_run, m_wait, m_pend_v, m_flush, m_exc;
    logic [31:0] m_pc, m_pend_t;

    function automatic logic [31:0] exp_target(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t % 4 != 0) ? 32'h0000_0010 : t;
`else
        return t - (t % 4);
`endif
    endfunction

    function automatic logic exp_trap(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t % 4 != 0);
`else
        return (t === 32'hxxxx_xxxx);
`endif
    endfunction

    function automatic logic exp_fetch_valid();
        return m_run && !m_wait && !bus.IMEM_BUSYWAIT && !bus.BRANCH_TAKEN && !m_flush;
    endfunction

    task automatic drive(input logic b, input logic s, input logic br, input logic [31:0] t);
        bus.IMEM_BUSYWAIT = b;
        bus.STALL         = s;
        bus.BRANCH_TAKEN  = br;
        bus.BRANCH_TARGET = t;
    endtask

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_pend_v = 0; m_pend_t = 0;
        m_flush = 0; m_exc = 0; m_pc = 32'h0;
    endtask

    task automatic tick();
        logic        n_wait, n_pv, n_fl, n_ex, req_v;
        logic [31:0] n_pc, n_pt, req_t;
        n_wait = m_wait; n_pv = m_pend_v; n_pt = m_pend_t; n_pc = m_pc; n_fl = 0; n_ex = 0;
        if (m_run) begin
            req_v = bus.BRANCH_TAKEN || m_pend_v;
            req_t = bus.BRANCH_TAKEN ? bus.BRANCH_TARGET : m_pend_t;
            if (bus.IMEM_BUSYWAIT) begin
                n_wait = 1; n_pv = req_v; n_pt = req_t;
            end else begin
                n_wait = 0; n_pv = 0;
                if (req_v) begin
                    n_pc = exp_target(req_t); n_fl = 1; n_ex = exp_trap(req_t);
                end else if (!bus.STALL) begin
                    n_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        m_run = 1; m_wait = n_wait; m_pend_v = n_pv; m_pend_t = n_pt;
        m_pc = n_pc; m_flush = n_fl; m_exc = n_ex;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #2;
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", bus.PC, 32'h0); end
        n_cmp++; if (bus.IMEM_READ !== 1'b0) begin n_bad++; $display("FAIL reset_imem_read got=%b exp=0", bus.IMEM_READ); end
        n_cmp++; if ({bus.FLUSH_IFID, bus.FLUSH_IDEX, bus.MISALIGN_EXC, bus.FETCH_VALID} !== 4'b0)
            begin n_bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.FLUSH_IFID, bus.FLUSH_IDEX, bus.MISALIGN_EXC, bus.FETCH_VALID}); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        tick();
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++; $display("FAIL seq_first_pc got=%h exp=%h", bus.PC, 32'h0); end
        n_cmp++; if (bus.IMEM_READ !== 1'b1) begin n_bad++; $display("FAIL seq_imem_read got=%b exp=1", bus.IMEM_READ); end
        n_cmp++; if (bus.FETCH_VALID !== 1'b1) begin n_bad++; $display("FAIL seq_fetch_valid got=%b exp=1", bus.FETCH_VALID); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = 32'(i * 4);
            n_cmp++; if (bus.PC !== exp) begin n_bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.PC, exp); end
        end
    endtask

    task automatic test_branch_idle();
        do_reset();
        tick(); tick();
        drive(0, 0, 1, 32'h100);
        #1;
        n_cmp++; if (bus.FETCH_VALID !== 1'b0) begin n_bad++; $display("FAIL br_idle_fv_req got=%b exp=0", bus.FETCH_VALID); end
        tick();
        drive(0, 0, 0, 32'h0);
        #1;
        n_cmp++; if (bus.PC !== 32'h100) begin n_bad++; $display("FAIL br_idle_pc got=%h exp=%h", bus.PC, 32'h100); end
        n_cmp++; if ({bus.FLUSH_IFID, bus.FLUSH_IDEX} !== 2'b11) begin n_bad++; $display("FAIL br_idle_flush got=%b exp=11", {bus.FLUSH_IFID, bus.FLUSH_IDEX}); end
        n_cmp++; if (bus.FETCH_VALID !== 1'b0) begin n_bad++; $display("FAIL br_idle_fv got=%b exp=0", bus.FETCH_VALID); end
        tick();
        n_cmp++; if ({bus.FLUSH_IFID, bus.FLUSH_IDEX} !== 2'b00) begin n_bad++; $display("FAIL br_idle_flush_end got=%b exp=00", {bus.FLUSH_IFID, bus.FLUSH_IDEX}); end
        n_cmp++; if (bus.PC !== 32'h104) begin n_bad++; $display("FAIL br_idle_next got=%h exp=%h", bus.PC, 32'h104); end
    endtask

    task automatic test_branch_busy();
        do_reset();
        drive(1, 0, 1, 32'h200);
        tick();
        drive(1, 0, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (bus.PC !== 32'h0 || bus.FLUSH_IFID !== 1'b0) begin n_bad++; $display("FAIL br_busy_hold%0d got=%h/%b exp=0/0", i, bus.PC, bus.FLUSH_IFID); end
            tick();
        end
        drive(0, 0, 0, 32'h0);
        tick();
        n_cmp++; if (bus.PC !== 32'h200) begin n_bad++; $display("FAIL br_busy_pc got=%h exp=%h", bus.PC, 32'h200); end
        n_cmp++; if (bus.FLUSH_IDEX !== 1'b1) begin n_bad++; $display("FAIL br_busy_flush got=%b exp=1", bus.FLUSH_IDEX); end
        tick();
        n_cmp++; if (bus.PC !== 32'h204 || bus.FLUSH_IDEX !== 1'b0) begin n_bad++; $display("FAIL br_busy_after got=%h/%b exp=204/0", bus.PC, bus.FLUSH_IDEX); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        drive(0, 1, 0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (bus.PC !== 32'h10) begin n_bad++; $display("FAIL stall_hold%0d got=%h exp=%h", i, bus.PC, 32'h10); end
        end
        drive(0, 0, 0, 32'h0);
        tick();
        n_cmp++; if (bus.PC !== 32'h14) begin n_bad++; $display("FAIL stall_release got=%h exp=%h", bus.PC, 32'h14); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(0, 0, 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 0, 32'h0);
        #1;
        n_cmp++; if (bus.PC_PLUS4 !== 32'h0) begin n_bad++; $display("FAIL wrap_plus4 got=%h exp=%h", bus.PC_PLUS4, 32'h0); end
        tick();
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++; $display("FAIL wrap_pc got=%h exp=%h", bus.PC, 32'h0); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_pc;
        logic        exp_exc;
`ifdef MISALIGN_TRAP_EN
        exp_pc = 32'h10;  exp_exc = 1'b1;
`else
        exp_pc = 32'h100; exp_exc = 1'b0;
`endif
        do_reset();
        drive(0, 0, 1, 32'h102);
        tick();
        drive(0, 0, 0, 32'h0);
        n_cmp++; if (bus.PC !== exp_pc) begin n_bad++; $display("FAIL misalign_pc got=%h exp=%h", bus.PC, exp_pc); end
        n_cmp++; if (bus.MISALIGN_EXC !== exp_exc) begin n_bad++; $display("FAIL misalign_exc got=%b exp=%b", bus.MISALIGN_EXC, exp_exc); end
        tick();
        n_cmp++; if (bus.MISALIGN_EXC !== 1'b0) begin n_bad++; $display("FAIL misalign_exc_end got=%b exp=0", bus.MISALIGN_EXC); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(); tick();
        drive(1, 0, 1, 32'h300);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.PC !== 32'h0) begin n_bad++; $display("FAIL areset_pc got=%h exp=%h", bus.PC, 32'h0); end
        n_cmp++; if (bus.IMEM_READ !== 1'b0) begin n_bad++; $display("FAIL areset_imem got=%b exp=0", bus.IMEM_READ); end
        drive(0, 0, 0, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.PC !== 32'h4 || bus.FLUSH_IFID !== 1'b0) begin n_bad++; $display("FAIL areset_no_pending got=%h/%b exp=4/0", bus.PC, bus.FLUSH_IFID); end
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 2, t);
            #1;
            n_cmp++; if (bus.FETCH_VALID !== exp_fetch_valid())
                begin n_bad++; $display("FAIL rand_fv[%0d] got=%b exp=%b", i, bus.FETCH_VALID, exp_fetch_valid()); end
            tick();
            n_cmp++; if (bus.PC !== m_pc || bus.PC_PLUS4 !== m_pc + 32'd4)
                begin n_bad++; $display("FAIL rand_pc[%0d] got=%h/%h exp=%h", i, bus.PC, bus.PC_PLUS4, m_pc); end
            n_cmp++; if ({bus.FLUSH_IFID, bus.FLUSH_IDEX, bus.MISALIGN_EXC, bus.IMEM_READ} !== {m_flush, m_flush, m_exc, m_run})
                begin n_bad++; $display("FAIL rand_ctl[%0d] got=%b exp=%b", i, {bus.FLUSH_IFID, bus.FLUSH_IDEX, bus.MISALIGN_EXC, bus.IMEM_READ}, {m_flush, m_flush, m_exc, m_run}); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_idle();
        test_branch_busy();
        test_stall();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
# pc_controller

Sequencer for the IF stage of the RV32IM pipeline. Owns the program-counter register and chooses each cycle between sequential advance, hold (hazard stall or instruction-memory busywait) and redirect (taken branch/jump resolved in EX). Issues the instruction-memory read strobe and the one-cycle pipeline flushes that follow a redirect. Sits between the hazard unit, the EX-stage branch logic and instruction memory.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0010, PC value loaded on a misaligned redirect (only with MISALIGN_TRAP_EN).
- CLOCK  in  1  sole clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IMEM_BUSYWAIT  in  1  instruction memory not ready; current fetch still in progress.
- STALL  in  1  hazard-unit hold request for IF.
- BRANCH_TAKEN  in  1  EX-stage redirect request, valid for one cycle.
- BRANCH_TARGET  in  32  redirect address, sampled with BRANCH_TAKEN.
- PC  out  32  current fetch address.
- PC_PLUS4  out  32  PC + 4, mod 2^32 (combinational).
- IMEM_READ  out  1  read strobe to instruction memory.
- FETCH_VALID  out  1  instruction at PC is delivered this cycle and may be captured by IF/ID.
- FLUSH_IFID  out  1  squash IF/ID register.
- FLUSH_IDEX  out  1  squash ID/EX register.
- MISALIGN_EXC  out  1  misaligned redirect detected.

## Operation
- States: IDLE, FETCH, WAIT_MEM. Internal: pend_valid, pend_target[31:0].
- Reset (RESET=0): PC=RESET_VECTOR, state=IDLE, pend_valid=0; IMEM_READ, FETCH_VALID, FLUSH_IFID, FLUSH_IDEX, MISALIGN_EXC all 0.
- IDLE: first rising edge with RESET=1 -> FETCH; PC unchanged.
- IMEM_READ = 1 in FETCH and WAIT_MEM, 0 in IDLE.
- FETCH_VALID = (state==FETCH) & ~IMEM_BUSYWAIT & ~BRANCH_TAKEN & ~FLUSH_IFID.
- FETCH, edge priority:
  - BRANCH_TAKEN & ~IMEM_BUSYWAIT: PC<=target, flush; stay FETCH.
  - BRANCH_TAKEN & IMEM_BUSYWAIT: pend_target<=target, pend_valid<=1, -> WAIT_MEM; PC holds.
  - IMEM_BUSYWAIT: -> WAIT_MEM; PC holds.
  - STALL: PC holds.
  - else PC<=PC+4.
- WAIT_MEM, edge:
  - BRANCH_TAKEN: pend_target<=target, pend_valid<=1 (latest request wins).
  - IMEM_BUSYWAIT=0: -> FETCH; if pend_valid (or BRANCH_TAKEN this cycle) PC<=pending target, flush, clear pend_valid; else if STALL hold; else PC<=PC+4.
- Flush: FLUSH_IFID and FLUSH_IDEX registered, high for exactly the one cycle following the edge that loads a redirect target; back-to-back redirects give back-to-back flush cycles.
- PC+4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
- RESET low at any time aborts immediately: pending redirect discarded, outputs to reset values without waiting for a clock edge.

## Timing
- Redirect latency: target visible on PC one cycle after the edge sampling BRANCH_TAKEN when memory is idle; otherwise one cycle after the edge on which IMEM_BUSYWAIT is low.
- Sequential throughput: one PC advance per cycle with no stall or busywait.
- STALL and IMEM_BUSYWAIT together: PC holds; STALL is not remembered across WAIT_MEM, it is re-sampled on exit.
- PC_PLUS4 and FETCH_VALID combinational from registered state and inputs; all other outputs registered.

## Configuration
- MISALIGN_TRAP_EN defined: applied redirect target with [1:0]!=0 loads TRAP_VECTOR instead, MISALIGN_EXC high for the same single cycle as the flushes.
- Not defined: target[1:0] forced to 2'b00 before loading; MISALIGN_EXC tied 0.

## Test plan
- Reset release, no stalls: PC = 0x0, then 0x4, 0x8, 0xC on successive edges; IMEM_READ=1 from first FETCH cycle.
- BRANCH_TAKEN with target 0x100 at PC=0x8, memory idle: next cycle PC=0x100, FLUSH_IFID=FLUSH_IDEX=1 for one cycle, FETCH_VALID=0 that cycle.
- BRANCH_TAKEN target 0x200 while IMEM_BUSYWAIT=1 for 3 cycles: PC holds, on busywait fall PC=0x200 with one flush cycle; no PC+4 step in between.
- STALL high 2 cycles at PC=0x10: PC stays 0x10 for both, then 0x14.
- PC forced to 0xFFFF_FFFC (redirect), then advance: next PC=0x0.
- Redirect to 0x102: with MISALIGN_TRAP_EN PC=0x10, MISALIGN_EXC=1 one cycle; without it PC=0x100, MISALIGN_EXC=0. Assert RESET low mid-WAIT_MEM: PC=0x0 asynchronously, pending redirect not applied after release.
